serial_adapter: RTL and testbench

SERIAL_ADAPTER -- requirements
Module: serial_adapter

---
 rtl/serial_adapter.sv | 207 ++++++++++++++++++++
 tb/tb_serial_adapter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adapter.sv
// 8N1 serial adapter with a four-register CPU bus interface.
// Independent TX and RX state machines share only the clock and the status/command registers.
module serial_adapter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chip_en,
  input  logic       READ_write,
  input  logic [1:0] register_select,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       rx,
  output logic       tx,
  output logic       irqb
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Bus decode
  logic wr_en, wr_data, wr_status, wr_cmd, rd_data;
  assign wr_en     = chip_en & READ_write;
  assign wr_data   = wr_en & (register_select == 2'd0);
  assign wr_status = wr_en & (register_select == 2'd1);
  assign wr_cmd    = wr_en & (register_select == 2'd2);
  assign rd_data   = chip_en & ~READ_write & (register_select == 2'd0);

  logic [7:0] holding, tx_shift, rx_shift, rx_data;
  logic       tx_empty, rx_full, overrun, framing_err;
  logic       rx_irq_en, tx_irq_en, irq_active;

  // ---------------- Transmitter ----------------
  state_t          tx_state, tx_next;
  logic [TW-1:0]   tx_timer;
  logic [2:0]      tx_bit_cnt;
  logic            tx_load, tx_tick;

  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    tx_tick = (tx_timer == BIT_LAST);
    case (tx_state)
      IDLE:  if (!tx_empty) begin
               tx_next = START;
               tx_load = 1'b1;
             end
      START: if (tx_tick) tx_next = DATA;
      DATA:  if (tx_tick && tx_bit_cnt == 3'd7) tx_next = STOP;
      STOP:  if (tx_tick) begin
               // Pending byte chains straight into the next start bit.
               if (!tx_empty) begin
                 tx_next = START;
                 tx_load = 1'b1;
               end else begin
                 tx_next = IDLE;
               end
             end
      default: tx_next = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (tx_state)
      START:   tx = 1'b0;
      DATA:    tx = tx_shift[0];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state   <= IDLE;
      tx_timer   <= '0;
      tx_bit_cnt <= '0;
      tx_shift   <= '0;
      holding    <= '0;
      tx_empty   <= 1'b1;
    end else begin
      tx_state <= tx_next;
      if (tx_load) begin
        tx_shift   <= holding;
        tx_timer   <= '0;
        tx_bit_cnt <= '0;
        tx_empty   <= 1'b1;
      end else if (tx_state != IDLE) begin
        if (tx_tick) begin
          tx_timer <= '0;
          if (tx_state == DATA) begin
            tx_shift   <= {1'b0, tx_shift[7:1]};
            tx_bit_cnt <= tx_bit_cnt + 3'd1;
          end
        end else begin
          tx_timer <= tx_timer + 1'b1;
        end
      end
      // A write on the same edge as a load still leaves a byte pending.
      if (wr_data) begin
        holding  <= data_in;
        tx_empty <= 1'b0;
      end
    end
  end

  // ---------------- Receiver ----------------
  logic            rx_s1, rx_s2, rx_prev;
  state_t          rx_state, rx_next;
  logic [TW-1:0]   rx_timer;
  logic [2:0]      rx_bit_cnt;
  logic            rx_fall, rx_full_tick, rx_half_tick, rx_done;

  assign rx_fall      = rx_prev & ~rx_s2;
  assign rx_full_tick = (rx_timer == BIT_LAST);
  assign rx_half_tick = (rx_timer == HALF_LAST);

  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    case (rx_state)
      IDLE:  if (rx_fall) rx_next = START;
      START: if (rx_half_tick) rx_next = rx_s2 ? IDLE : DATA;
      DATA:  if (rx_full_tick && rx_bit_cnt == 3'd7) rx_next = STOP;
      STOP:  if (rx_full_tick) begin
               rx_next = IDLE;
               rx_done = 1'b1;
             end
      default: rx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_prev     <= 1'b1;
      rx_state    <= IDLE;
      rx_timer    <= '0;
      rx_bit_cnt  <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_full     <= 1'b0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
      rx_irq_en   <= 1'b0;
      tx_irq_en   <= 1'b0;
      irqb        <= 1'b1;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_next;

      if (rx_state == IDLE || (rx_state == START && rx_half_tick) || rx_full_tick)
        rx_timer <= '0;
      else
        rx_timer <= rx_timer + 1'b1;

      if (rx_state == IDLE) begin
        rx_bit_cnt <= '0;
      end else if (rx_state == DATA && rx_full_tick) begin
        rx_shift   <= {rx_s2, rx_shift[7:1]};
        rx_bit_cnt <= rx_bit_cnt + 3'd1;
      end

      if (wr_status) begin
        overrun     <= 1'b0;
        framing_err <= 1'b0;
      end
      if (rd_data) rx_full <= 1'b0;
      // A read on the completion edge frees the buffer for the new byte.
      if (rx_done) begin
        if (!rx_full || rd_data) begin
          rx_data <= rx_shift;
          rx_full <= 1'b1;
          if (!rx_s2) framing_err <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      if (wr_cmd) begin
        rx_irq_en <= data_in[0];
        tx_irq_en <= data_in[1];
      end
      irqb <= ~irq_active;
    end
  end

  assign irq_active = (rx_irq_en & rx_full) | (tx_irq_en & tx_empty);

  always_comb begin
    data_out = '0;
    if (chip_en && !READ_write) begin
      case (register_select)
        2'd0:    data_out = rx_data;
        2'd1:    data_out = {irq_active, 3'b000, framing_err, overrun, tx_empty, rx_full};
        2'd2:    data_out = {6'b000000, tx_irq_en, rx_irq_en};
        default: data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adapter.sv
// Directed bench for serial_adapter: register-map vector table plus
// hand-timed TX/RX frame, IRQ and reset sequences.
module tb_serial_adapter;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       chip_en = 1'b0;
  logic       READ_write = 1'b0;
  logic [1:0] register_select = 2'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       tx, irqb;
  logic       rx_drv = 1'b1;
  logic       loop = 1'b0;
  logic       rx_line;

  assign rx_line = loop ? tx : rx_drv;

  serial_adapter #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .chip_en(chip_en), .READ_write(READ_write),
    .register_select(register_select), .data_in(data_in), .data_out(data_out),
    .rx(rx_line), .tx(tx), .irqb(irqb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    chip_en = 1'b1; READ_write = 1'b1; register_select = a; data_in = d;
    @(posedge clk); #1;
    chip_en = 1'b0; READ_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    chip_en = 1'b1; READ_write = 1'b0; register_select = a;
    #1 d = data_out;
    @(posedge clk); #1;
    chip_en = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  // Called just after the edge that enters START; checks every cycle of the frame.
  task automatic check_tx_frame(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10 * CPB; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      check("tx_frame", {7'b0, tx}, {7'b0, frame[k / CPB]});
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = stop;
    repeat (CPB) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  typedef struct {
    logic       cs;
    logic       rw;
    logic [1:0] rs;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;

    vecs[0]  = '{1'b1, 1'b0, 2'd1, 8'h00, 8'h02};
    vecs[1]  = '{1'b1, 1'b0, 2'd2, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 2'd3, 8'h00, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 1'b1, 2'd2, 8'hFF, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, 2'd2, 8'h00, 8'h03};
    vecs[6]  = '{1'b1, 1'b0, 2'd1, 8'h00, 8'h82};
    vecs[7]  = '{1'b0, 1'b0, 2'd2, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, 1'b1, 2'd3, 8'h55, 8'h00};
    vecs[9]  = '{1'b1, 1'b0, 2'd3, 8'h00, 8'h00};
    vecs[10] = '{1'b1, 1'b1, 2'd2, 8'h00, 8'h00};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 8'h00, 8'h00};
    vecs[12] = '{1'b1, 1'b1, 2'd1, 8'hFF, 8'h00};
    vecs[13] = '{1'b1, 1'b0, 2'd1, 8'h00, 8'h02};
    vecs[14] = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h00};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_tx", {7'b0, tx}, 8'h01);
    check("reset_irqb", {7'b0, irqb}, 8'h01);

    // Register map
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      chip_en = vecs[i].cs; READ_write = vecs[i].rw;
      register_select = vecs[i].rs; data_in = vecs[i].din;
      #1 check($sformatf("regmap_vec%0d", i), data_out, vecs[i].exp);
      @(posedge clk); #1;
      chip_en = 1'b0; READ_write = 1'b0;
    end

    // Single TX frame 0xA5
    bus_write(2'd0, 8'hA5);
    check("tx_idle_after_write", {7'b0, tx}, 8'h01);
    chip_en = 1'b1; READ_write = 1'b0; register_select = 2'd1;
    #1 check("status_tx_pending", data_out, 8'h00);
    @(posedge clk); #1;
    check("status_tx_empty_again", data_out, 8'h02);
    chip_en = 1'b0;
    check_tx_frame(8'hA5);
    @(posedge clk); #1;
    check("tx_idle_after_frame", {7'b0, tx}, 8'h01);

    // Back-to-back frames without idle gap
    bus_write(2'd0, 8'h01);
    @(posedge clk); #1;
    fork
      check_tx_frame(8'h01);
      begin
        repeat (3) @(posedge clk);
        bus_write(2'd0, 8'h02);
      end
    join
    @(posedge clk); #1;
    check_tx_frame(8'h02);
    @(posedge clk); #1;
    check("tx_idle_after_b2b", {7'b0, tx}, 8'h01);
    read_check("status_after_b2b", 2'd1, 8'h02);

    // RX byte
    send_rx(8'h3C, 1'b1);
    repeat (2) @(posedge clk);
    read_check("rx_status_full", 2'd1, 8'h03);
    read_check("rx_data_3c", 2'd0, 8'h3C);
    read_check("rx_status_cleared", 2'd1, 8'h02);

    // Overrun then framing error
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (2) @(posedge clk);
    read_check("overrun_status", 2'd1, 8'h07);
    bus_write(2'd1, 8'h00);
    read_check("overrun_cleared", 2'd1, 8'h03);
    read_check("overrun_kept_first", 2'd0, 8'h11);
    read_check("overrun_status_empty", 2'd1, 8'h02);
    send_rx(8'h55, 1'b0);
    repeat (2) @(posedge clk);
    read_check("framing_status", 2'd1, 8'h0B);
    read_check("framing_data", 2'd0, 8'h55);
    bus_write(2'd1, 8'hFF);
    read_check("framing_cleared", 2'd1, 8'h02);

    // False start: short low pulse
    @(negedge clk); rx_drv = 1'b0;
    repeat (4) @(negedge clk); rx_drv = 1'b1;
    repeat (40) @(posedge clk);
    read_check("false_start_status", 2'd1, 8'h02);

    // IRQ on receive, cleared by read; TX-empty IRQ
    bus_write(2'd2, 8'h01);
    @(posedge clk); #1;
    check("irqb_no_cause", {7'b0, irqb}, 8'h01);
    fork
      send_rx(8'h5A, 1'b1);
      begin
        chip_en = 1'b1; READ_write = 1'b0; register_select = 2'd1;
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
          @(posedge clk); #1;
          if (data_out[0]) found = 1'b1;
        end
        check("irq_rx_full_seen", {7'b0, found}, 8'h01);
        check("irq_status", data_out, 8'h83);
        check("irqb_before_flop", {7'b0, irqb}, 8'h01);
        @(posedge clk); #1;
        check("irqb_asserted", {7'b0, irqb}, 8'h00);
        chip_en = 1'b0;
      end
    join
    read_check("irq_rx_data", 2'd0, 8'h5A);
    check("irqb_still_low", {7'b0, irqb}, 8'h00);
    @(posedge clk); #1;
    check("irqb_released", {7'b0, irqb}, 8'h01);
    bus_write(2'd2, 8'h02);
    check("irqb_tx_pre", {7'b0, irqb}, 8'h01);
    @(posedge clk); #1;
    check("irqb_tx_empty", {7'b0, irqb}, 8'h00);
    bus_write(2'd2, 8'h00);

    // Loopback rx <- tx
    loop = 1'b1;
    bus_write(2'd0, 8'hC3);
    repeat (180) @(posedge clk);
    read_check("loop_status", 2'd1, 8'h03);
    read_check("loop_data", 2'd0, 8'hC3);
    loop = 1'b0;

    // Reset in the middle of TX data bit 3 with a byte pending
    bus_write(2'd2, 8'h03);
    bus_write(2'd0, 8'h5A);
    repeat (70) @(posedge clk);
    bus_write(2'd0, 8'h77);
    @(negedge clk);
    reset = 1'b1;
    chip_en = 1'b1; READ_write = 1'b0; register_select = 2'd1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_tx", {7'b0, tx}, 8'h01);
    check("midreset_irqb", {7'b0, irqb}, 8'h01);
    check("midreset_status", data_out, 8'h02);
    register_select = 2'd2;
    #1 check("midreset_cmd", data_out, 8'h00);
    register_select = 2'd0;
    #1 check("midreset_rxdata", data_out, 8'h00);
    chip_en = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      check("midreset_tx_stays_idle", {7'b0, tx}, 8'h01);
    end

    // Writes while reset is held are ignored
    @(negedge clk);
    reset = 1'b1;
    chip_en = 1'b1; READ_write = 1'b1; register_select = 2'd0; data_in = 8'h99;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chip_en = 1'b0; READ_write = 1'b0;
    read_check("reset_ignores_write", 2'd1, 8'h02);
    repeat (3) @(posedge clk);
    #1 check("reset_ignores_write_tx", {7'b0, tx}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
